bcd_scan_scheduler: RTL and testbench

- Time-multiplexing controller for the BCD display datapath of tt_um_BDC.
- Accepts a packed multi-digit BCD value through a valid/ready handshake and double-buffers it.
- Commits new values only at frame boundaries, so the display never tears.
- Scans one digit at a time onto a shared 7-segment bus, with a blanking gap between digits against ghosting, leading-zero suppression and invalid-digit flagging.

---
 rtl/bcd_scan_scheduler_pkg.sv | 32 +++
 rtl/bcd_scan_scheduler_bcd_to_seg.sv | 29 ++
 rtl/bcd_scan_scheduler.sv | 157 +++++++++++++++
 tb/tb_bcd_scan_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_scheduler_pkg.sv
// Shared types and constants for the BCD display scan scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bcd_scan_scheduler_pkg;

  // ON: current digit lit; BLANK: dark gap between digits against ghosting.
  typedef enum logic {
    ON    = 1'b0,
    BLANK = 1'b1
  } state_t;

  // Segment patterns, bit 0 = a ... bit 6 = g, active high.
  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/bcd_scan_scheduler_bcd_to_seg.sv
// Combinational BCD nibble to 7-segment decoder; non-decimal nibbles show a dash.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
// Ports: bcd (4-bit nibble in), seg (7-bit pattern out, seg[0]=a).
module bcd_to_seg
  import bcd_scan_scheduler_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_scan_scheduler.sv
// Time-multiplexed BCD display scanner with a double-buffered load port; new values commit only at frame wrap.
// Latency: seg/dig_en/bcd_err registered, 1 cycle behind scan state; a load appears after the next frame boundary.
// Backpressure: load_ready low while the shadow buffer holds an uncommitted value; requester holds bcd_in.
// Ports: clk, rst (sync, active high), ena (scan enable), bcd_in/load_valid/load_ready (load handshake),
//        lz_suppress (leading-zero blanking), seg, dig_en (one-hot), frame_done (pulse), bcd_err.
module bcd_scan_scheduler
  import bcd_scan_scheduler_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int DIGIT_CYCLES = 1000,
  parameter int BLANK_CYCLES = 50
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic [4*N_DIGITS-1:0] bcd_in,
  input  logic                  load_valid,
  output logic                  load_ready,
  input  logic                  lz_suppress,
  output logic [6:0]            seg,
  output logic [N_DIGITS-1:0]   dig_en,
  output logic                  frame_done,
  output logic                  bcd_err
);

  localparam int CW = $clog2(max3(DIGIT_CYCLES, BLANK_CYCLES, 2));
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] ON_LAST    = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST   = IW'(N_DIGITS - 1);

  state_t                state, state_nxt;
  logic [IW-1:0]         idx, idx_nxt;
  logic [CW-1:0]         cyc, cyc_nxt;
  logic                  advance, wrap;

  logic [4*N_DIGITS-1:0] disp, pend;
  logic                  pend_full;
  logic                  accept;

  logic [3:0]            nib [N_DIGITS];
  logic [N_DIGITS-1:0]   bad, tail_zero, onehot;
  logic [6:0]            seg_dec;
  logic                  lit, hide;

  // ---------------- scan FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ON;
      idx   <= '0;
      cyc   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      cyc   <= cyc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cyc_nxt   = cyc;
    advance   = 1'b0;
    wrap      = 1'b0;
    if (ena) begin
      case (state)
        ON: begin
          if (cyc == ON_LAST) begin
            cyc_nxt = '0;
            // With no blanking gap the digit advances straight out of ON.
            if (BLANK_CYCLES == 0) advance = 1'b1;
            else                   state_nxt = BLANK;
          end else begin
            cyc_nxt = cyc + CW'(1);
          end
        end
        BLANK: begin
          if (cyc == BLANK_LAST) begin
            cyc_nxt   = '0;
            state_nxt = ON;
            advance   = 1'b1;
          end else begin
            cyc_nxt = cyc + CW'(1);
          end
        end
        default: state_nxt = ON;
      endcase
      if (advance) begin
        if (idx == IDX_LAST) begin
          idx_nxt = '0;
          wrap    = 1'b1;
        end else begin
          idx_nxt = idx + IW'(1);
        end
      end
    end
  end

  // ---------------- digit inspection ----------------
  for (genvar g = 0; g < N_DIGITS; g++) begin : g_nib
    assign nib[g] = disp[4*g +: 4];
  end

  // tail_zero[i]: digits i..N_DIGITS-1 are all zero.
  always_comb begin
    bad       = '0;
    tail_zero = '0;
    for (int i = 0; i < N_DIGITS; i++) bad[i] = (nib[i] > 4'd9);
    tail_zero[N_DIGITS-1] = (nib[N_DIGITS-1] == 4'd0);
    for (int i = N_DIGITS - 2; i >= 0; i--)
      tail_zero[i] = (nib[i] == 4'd0) && tail_zero[i+1];
  end

  always_comb begin
    onehot      = '0;
    onehot[idx] = 1'b1;
  end

  bcd_to_seg u_dec (
    .bcd (nib[idx]),
    .seg (seg_dec)
  );

  assign lit  = ena && (state == ON);
  // Digit 0 always shows, so a zero value still reads "0".
  assign hide = lz_suppress && (idx != '0) && tail_zero[idx];

  // ---------------- buffers and registered outputs ----------------
  assign load_ready = !pend_full;
  assign accept     = load_valid && !pend_full;

  always_ff @(posedge clk) begin
    if (rst) begin
      disp       <= '0;
      pend       <= '0;
      pend_full  <= 1'b0;
      seg        <= SEG_OFF;
      dig_en     <= '0;
      frame_done <= 1'b0;
      bcd_err    <= 1'b0;
    end else begin
      // Commit and accept are exclusive: accept needs pend empty, commit needs it full.
      if (wrap && pend_full) begin
        disp      <= pend;
        pend_full <= 1'b0;
      end else if (accept) begin
        pend      <= bcd_in;
        pend_full <= 1'b1;
      end
      frame_done <= wrap;
      seg        <= (lit && !hide) ? seg_dec : SEG_OFF;
      dig_en     <= lit ? onehot : '0;
      bcd_err    <= |bad;
    end
  end

endmodule

// File: tb/tb_bcd_scan_scheduler.sv
// Directed bench for bcd_scan_scheduler with 4 digits, 4 lit cycles, 2 blank cycles (24-cycle frame).
// Scan position advances only on edges where ena was high; expected digit patterns are hand-set per frame.
module tb_bcd_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic [15:0] bcd_in;
  logic        load_valid;
  logic        load_ready;
  logic        lz_suppress;
  logic [6:0]  seg;
  logic [3:0]  dig_en;
  logic        frame_done;
  logic        bcd_err;

  int          vectors = 0;
  int          miscompares = 0;
  int          pos;
  logic [6:0]  exp_seg [4];
  logic        exp_err;

  bcd_scan_scheduler #(
    .N_DIGITS     (4),
    .DIGIT_CYCLES (4),
    .BLANK_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ena         (ena),
    .bcd_in      (bcd_in),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .lz_suppress (lz_suppress),
    .seg         (seg),
    .dig_en      (dig_en),
    .frame_done  (frame_done),
    .bcd_err     (bcd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s pos=%0d: observed %h expected %h", tag, pos, got, exp);
    end
  endtask

  task automatic set_exp(input logic [6:0] d0, input logic [6:0] d1,
                         input logic [6:0] d2, input logic [6:0] d3);
    exp_seg[0] = d0;
    exp_seg[1] = d1;
    exp_seg[2] = d2;
    exp_seg[3] = d3;
  endtask

  // One clock edge, then check the registered outputs against the frame position before the edge.
  task automatic step();
    logic       was_ena;
    logic       was_rst;
    int         op;
    int         r;
    int         d;
    logic [3:0] e_dig;
    logic [6:0] e_seg;
    logic       e_fd;
    was_ena = ena;
    was_rst = rst;
    op      = pos;
    @(posedge clk);
    #1;
    e_dig = 4'b0000;
    e_seg = 7'h00;
    e_fd  = 1'b0;
    if (was_rst) begin
      pos = 0;
    end else if (was_ena) begin
      r = op % 6;
      d = (op % 24) / 6;
      if (r < 4) begin
        e_dig = 4'b0001 << d;
        e_seg = exp_seg[d];
      end
      e_fd = ((op % 24) == 23);
      pos  = op + 1;
    end
    chk("dig_en",     16'(dig_en),     16'(e_dig));
    chk("seg",        16'(seg),        16'(e_seg));
    chk("frame_done", 16'(frame_done), 16'(e_fd));
    chk("bcd_err",    16'(bcd_err),    16'(exp_err));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst         = 1'b1;
    ena         = 1'b0;
    load_valid  = 1'b0;
    lz_suppress = 1'b0;
    bcd_in      = 16'h0000;
    pos         = 0;
    exp_err     = 1'b0;
    set_exp(7'h3F, 7'h3F, 7'h3F, 7'h3F);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_seg",        16'(seg),        16'h0000);
    chk("rst_dig_en",     16'(dig_en),     16'h0000);
    chk("rst_frame_done", 16'(frame_done), 16'h0000);
    chk("rst_bcd_err",    16'(bcd_err),    16'h0000);
    chk("rst_load_ready", 16'(load_ready), 16'h0001);
    rst = 1'b0;
    ena = 1'b1;

    // Idle scan of zero, then load 0x1234 on the fourth edge
    run(3);
    chk("ready_idle", 16'(load_ready), 16'h0001);
    load_valid = 1'b1;
    bcd_in     = 16'h1234;
    step();
    load_valid = 1'b0;
    chk("ready_after_1234", 16'(load_ready), 16'h0000);
    run(20);
    chk("ready_after_commit_1234", 16'(load_ready), 16'h0001);
    set_exp(7'h66, 7'h4F, 7'h5B, 7'h06);
    run(24);

    // Back-to-back loads: 0x2222 stalls until 0x1111 commits
    load_valid = 1'b1;
    bcd_in     = 16'h1111;
    step();
    bcd_in = 16'h2222;
    chk("ready_stall", 16'(load_ready), 16'h0000);
    run(23);
    chk("ready_rise", 16'(load_ready), 16'h0001);
    set_exp(7'h06, 7'h06, 7'h06, 7'h06);
    step();
    load_valid = 1'b0;
    chk("ready_after_2222", 16'(load_ready), 16'h0000);
    run(23);
    chk("ready_after_commit_2222", 16'(load_ready), 16'h0001);
    set_exp(7'h5B, 7'h5B, 7'h5B, 7'h5B);

    // Leading-zero suppression on 0x0070
    lz_suppress = 1'b1;
    load_valid  = 1'b1;
    bcd_in      = 16'h0070;
    step();
    load_valid = 1'b0;
    run(23);
    set_exp(7'h3F, 7'h07, 7'h00, 7'h00);
    run(24);
    lz_suppress = 1'b0;
    set_exp(7'h3F, 7'h07, 7'h3F, 7'h3F);

    // Invalid digit 0x00A5 raises bcd_err one cycle after commit
    load_valid = 1'b1;
    bcd_in     = 16'h00A5;
    step();
    load_valid = 1'b0;
    run(23);
    set_exp(7'h6D, 7'h40, 7'h3F, 7'h3F);
    exp_err = 1'b1;

    // 0x0005 clears bcd_err after its commit
    load_valid = 1'b1;
    bcd_in     = 16'h0005;
    step();
    load_valid = 1'b0;
    run(23);
    set_exp(7'h6D, 7'h3F, 7'h3F, 7'h3F);
    exp_err = 1'b0;
    run(13);

    // Pause mid-ON of digit 2; handshake still accepts
    ena        = 1'b0;
    load_valid = 1'b1;
    bcd_in     = 16'h9999;
    step();
    load_valid = 1'b0;
    chk("ready_while_paused", 16'(load_ready), 16'h0000);
    run(9);
    ena = 1'b1;
    run(7);

    // Reset mid-frame discards the pending 0x9999
    rst = 1'b1;
    step();
    chk("ready_after_rst", 16'(load_ready), 16'h0001);
    rst = 1'b0;
    set_exp(7'h3F, 7'h3F, 7'h3F, 7'h3F);
    run(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
